// File: rtl/fetch_stage_ctrl.sv
// IF stage: PC register and IF/DE fetch buffer, driven by the hazard-detect stall triple and EX redirects.
// Also tracks halt, sticky stall-protocol errors and saturating stall/flush counts.
module fetch_stage_ctrl #(
  parameter int unsigned          PC_W      = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  parameter logic [3:0]           HALT_OP   = 4'hF,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pcenable,
  input  logic               fetchbuffenable,
  input  logic               zerocontrol,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifde_instr,
  output logic [PC_W-1:0]    ifde_pc,
  output logic               ifde_valid,
  output logic               halted,
  output logic               proto_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifde_pc_q, ifde_pc_d;
  logic               valid_q, valid_d;
  logic               proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic stall_c;
  logic proto_bad_c;
  logic halt_op_c;

  assign stall_c     = !pcenable || !fetchbuffenable;
  assign proto_bad_c = (pcenable != fetchbuffenable) || (zerocontrol != !pcenable);
  assign halt_op_c   = valid_q && (instr_q[INSTR_W-1 -: 4] == HALT_OP);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      ifde_pc_q   <= '0;
      valid_q     <= 1'b0;
      proto_err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ifde_pc_q   <= ifde_pc_d;
      valid_q     <= valid_d;
      proto_err_q <= proto_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state: redirect > halt detect > stall > advance; HALT freezes everything
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ifde_pc_d   = ifde_pc_q;
    valid_d     = valid_q;
    proto_err_d = proto_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (state_q != ST_HALT) begin
      if (proto_bad_c) begin
        proto_err_d = 1'b1;
      end

      if (br_taken) begin
        pc_d    = {br_target[PC_W-1:1], 1'b0};
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (flush_cnt_q != CNT_MAX) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        state_d = ST_RUN;
      end else if (halt_op_c) begin
        state_d = ST_HALT;
      end else if (stall_c) begin
        if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        state_d = ST_STALL;
      end else begin
        pc_d      = pc_q + PC_W'(2);
        instr_d   = imem_rdata;
        ifde_pc_d = pc_q + PC_W'(2);
        valid_d   = 1'b1;
        state_d   = ST_RUN;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign ifde_instr = instr_q;
  assign ifde_pc    = ifde_pc_q;
  assign ifde_valid = valid_q;
  assign halted     = (state_q == ST_HALT);
  assign proto_err  = proto_err_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pcenable, fetchbuffenable, zerocontrol, br_taken;
  logic [15:0]       br_target;
  logic [15:0]       imem_addr, imem_rdata;
  logic [15:0]       ifde_instr, ifde_pc;
  logic              ifde_valid, halted, proto_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic [15:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0]      m_pc, m_instr, m_ifde_pc;
  logic             m_valid, m_halt, m_perr;
  logic [CNT_W-1:0] m_scnt, m_fcnt;

  fetch_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pcenable(pcenable), .fetchbuffenable(fetchbuffenable), .zerocontrol(zerocontrol),
    .br_taken(br_taken), .br_target(br_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifde_instr(ifde_instr), .ifde_pc(ifde_pc), .ifde_valid(ifde_valid),
    .halted(halted), .proto_err(proto_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[8:1]];

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ifde_pc = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; m_perr = 1'b0; m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic drive(input logic pe, input logic fe, input logic zc, input logic br, input logic [15:0] tgt);
    pcenable = pe; fetchbuffenable = fe; zerocontrol = zc; br_taken = br; br_target = tgt;
  endtask

  // One clock edge; the model applies the rules to the inputs currently driven
  task automatic step();
    logic [15:0] n_pc, n_instr, n_ifde_pc;
    logic n_valid, n_halt, n_perr;
    logic [CNT_W-1:0] n_scnt, n_fcnt;
    n_pc = m_pc; n_instr = m_instr; n_ifde_pc = m_ifde_pc; n_valid = m_valid;
    n_halt = m_halt; n_perr = m_perr; n_scnt = m_scnt; n_fcnt = m_fcnt;
    if (!m_halt) begin
      if ((pcenable != fetchbuffenable) || (zerocontrol == pcenable)) n_perr = 1'b1;
      if (br_taken) begin
        n_pc = br_target & 16'hFFFE; n_instr = 16'h0000; n_valid = 1'b0;
        if (m_fcnt != CMAX) n_fcnt = m_fcnt + 1'b1;
      end else if (m_valid && m_instr[15:12] == 4'hF) begin
        n_halt = 1'b1;
      end else if (!pcenable || !fetchbuffenable) begin
        if (m_scnt != CMAX) n_scnt = m_scnt + 1'b1;
      end else begin
        n_instr = mem[m_pc[8:1]]; n_pc = m_pc + 16'd2; n_ifde_pc = m_pc + 16'd2; n_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_ifde_pc = n_ifde_pc; m_valid = n_valid;
    m_halt = n_halt; m_perr = n_perr; m_scnt = n_scnt; m_fcnt = n_fcnt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_mem(input int halt_pct);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom) & 16'h7FFF;
      if (int'($urandom_range(0, 99)) < halt_pct) mem[i] = 16'hF000 | (16'($urandom) & 16'h0FFF);
    end
  endtask

  task automatic test_reset();
    fill_mem(0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    model_reset();
    #12;
    total++;
    if (imem_addr !== 16'h0000 || ifde_instr !== 16'h0000 || ifde_pc !== 16'h0000 || ifde_valid !== 1'b0 ||
        halted !== 1'b0 || proto_err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++;
      $display("FAIL reset: addr=%h instr=%h pc=%h v=%b h=%b pe=%b sc=%0d fc=%0d required all zero",
               imem_addr, ifde_instr, ifde_pc, ifde_valid, halted, proto_err, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    total++;
    if (ifde_instr !== 16'h1234 || ifde_pc !== 16'h0002 || ifde_valid !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL fetch_edge1: instr=%h pc=%h v=%b addr=%h required 1234 0002 1 0002", ifde_instr, ifde_pc, ifde_valid, imem_addr);
    end
    step();
    total++;
    if (ifde_instr !== 16'h5678 || ifde_pc !== 16'h0004 || imem_addr !== 16'h0004) begin
      bad++;
      $display("FAIL fetch_edge2: instr=%h pc=%h addr=%h required 5678 0004 0004", ifde_instr, ifde_pc, imem_addr);
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    step();
    total++;
    if (imem_addr !== 16'h0004 || ifde_instr !== 16'h5678 || ifde_pc !== 16'h0004 || stall_cnt !== 4'd2 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL stall: addr=%h instr=%h pc=%h sc=%0d pe=%b required 0004 5678 0004 2 0", imem_addr, ifde_instr, ifde_pc, stall_cnt, proto_err);
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0041);
    step();
    total++;
    if (imem_addr !== 16'h0040 || ifde_instr !== 16'h0000 || ifde_valid !== 1'b0 || ifde_pc !== 16'h0004 ||
        flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL flush: addr=%h instr=%h v=%b pc=%h fc=%0d sc=%0d required 0040 0000 0 0004 1 2",
               imem_addr, ifde_instr, ifde_valid, ifde_pc, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_proto();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    total++;
    if (imem_addr !== 16'h0040 || stall_cnt !== 4'd3 || proto_err !== 1'b1 || ifde_valid !== 1'b0) begin
      bad++;
      $display("FAIL proto_stall: addr=%h sc=%0d pe=%b v=%b required 0040 3 1 0", imem_addr, stall_cnt, proto_err, ifde_valid);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    total++;
    if (proto_err !== 1'b1 || imem_addr !== 16'h0042 || ifde_instr !== mem[8'h20]) begin
      bad++;
      $display("FAIL proto_sticky: pe=%b addr=%h instr=%h required 1 0042 %h", proto_err, imem_addr, ifde_instr, mem[8'h20]);
    end
  endtask

  task automatic test_halt();
    mem[8'h21] = 16'hF000;
    step();
    total++;
    if (ifde_instr !== 16'hF000 || halted !== 1'b0 || imem_addr !== 16'h0044) begin
      bad++;
      $display("FAIL halt_fetch: instr=%h h=%b addr=%h required F000 0 0044", ifde_instr, halted, imem_addr);
    end
    step();
    total++;
    if (halted !== 1'b1 || imem_addr !== 16'h0044 || ifde_instr !== 16'hF000) begin
      bad++;
      $display("FAIL halt_enter: h=%b addr=%h instr=%h required 1 0044 F000", halted, imem_addr, ifde_instr);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
    step();
    step();
    total++;
    if (halted !== 1'b1 || imem_addr !== 16'h0044 || ifde_instr !== 16'hF000 || flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
      bad++;
      $display("FAIL halt_hold: h=%b addr=%h instr=%h fc=%0d sc=%0d required 1 0044 F000 1 3",
               halted, imem_addr, ifde_instr, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_wrap_async_reset();
    fill_mem(0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFE);
    apply_reset();
    step();
    total++;
    if (imem_addr !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_redirect: addr=%h required FFFE", imem_addr);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    total++;
    if (imem_addr !== 16'h0000 || ifde_pc !== 16'h0000 || ifde_instr !== mem[8'hFF] || ifde_valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_pc: addr=%h pc=%h instr=%h v=%b required 0000 0000 %h 1", imem_addr, ifde_pc, ifde_instr, ifde_valid, mem[8'hFF]);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (imem_addr !== 16'h0000 || ifde_instr !== 16'h0000 || ifde_pc !== 16'h0000 || ifde_valid !== 1'b0 ||
        halted !== 1'b0 || proto_err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++;
      $display("FAIL async_reset: addr=%h instr=%h pc=%h v=%b h=%b pe=%b sc=%0d fc=%0d required all zero",
               imem_addr, ifde_instr, ifde_pc, ifde_valid, halted, proto_err, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    apply_reset();
    for (int i = 0; i < 20; i++) step();
    total++;
    if (stall_cnt !== CMAX || imem_addr !== 16'h0000 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL stall_saturate: sc=%0d addr=%h pe=%b required %0d 0000 0", stall_cnt, imem_addr, proto_err, CMAX);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
    for (int i = 0; i < 18; i++) step();
    total++;
    if (flush_cnt !== CMAX || stall_cnt !== CMAX || ifde_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_saturate: fc=%0d sc=%0d v=%b required %0d %0d 0", flush_cnt, stall_cnt, ifde_valid, CMAX, CMAX);
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 5; blk++) begin
      fill_mem(3);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      apply_reset();
      for (int cyc = 0; cyc < 150; cyc++) begin
        int r;
        logic [2:0] bits;
        r = int'($urandom_range(0, 99));
        bits = 3'($urandom);
        if (r < 65)      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        else if (r < 85) drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        else if (r < 93) drive(bits[0], bits[1], bits[2], 1'b0, 16'h0000);
        else             drive(bits[0], bits[1], bits[2], 1'b1, 16'($urandom));
        step();
        total++;
        if (imem_addr !== m_pc || ifde_instr !== m_instr || ifde_pc !== m_ifde_pc || ifde_valid !== m_valid ||
            halted !== m_halt || proto_err !== m_perr || stall_cnt !== m_scnt || flush_cnt !== m_fcnt) begin
          bad++;
          $display("FAIL random blk%0d cyc%0d: got addr=%h instr=%h pc=%h v=%b h=%b pe=%b sc=%0d fc=%0d required %h %h %h %b %b %b %0d %0d",
                   blk, cyc, imem_addr, ifde_instr, ifde_pc, ifde_valid, halted, proto_err, stall_cnt, flush_cnt,
                   m_pc, m_instr, m_ifde_pc, m_valid, m_halt, m_perr, m_scnt, m_fcnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_proto();
    test_halt();
    test_wrap_async_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
